// File: rtl/sram_confreg.sv
// sram_confreg: memory-mapped configuration/peripheral registers on the data
// SRAM port. It decodes one 64 KB physical window and provides the timer,
// compare interrupt, LED, seven-segment number, switch input and simulation
// flag registers. Read data is registered, giving the one-cycle SRAM latency.
module sram_confreg #(
    parameter logic [31:0] BASE = 32'h1faf_0000,
    parameter logic        SIMU = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        timer_int
);

    localparam logic [15:0] OFF_TIMER   = 16'he000;
    localparam logic [15:0] OFF_COMPARE = 16'he004;
    localparam logic [15:0] OFF_LED     = 16'hf000;
    localparam logic [15:0] OFF_NUM     = 16'hf010;
    localparam logic [15:0] OFF_SWITCH  = 16'hf020;
    localparam logic [15:0] OFF_SIMU    = 16'hfff0;

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  wen
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = wen[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    logic        hit_s;
    logic        wr_s;
    logic        rd_s;
    logic [15:0] word_off_s;
    logic        sel_timer_s;
    logic        sel_compare_s;
    logic        sel_led_s;
    logic        sel_num_s;
    logic        sel_switch_s;
    logic        sel_simu_s;
    logic [31:0] rd_mux_s;
    logic [31:0] led_merge_s;
    logic        addr_unused_s;

    logic [31:0] timer_r;
    logic [31:0] compare_r;
    logic [15:0] led_r;
    logic [31:0] num_r;
    logic [7:0]  sw_meta_r;
    logic [7:0]  sw_sync_r;
    logic        timer_int_r;
    logic [31:0] rdata_r;

    // Byte offset bits [1:0] select nothing; only the upper LED merge bits are discarded too.
    assign addr_unused_s = ^{data_sram_addr[1:0], led_merge_s[31:16]};

    assign hit_s      = data_sram_en & (data_sram_addr[31:16] == BASE[31:16]);
    assign wr_s       = hit_s & (|data_sram_wen);
    assign rd_s       = hit_s & (data_sram_wen == 4'b0000);
    assign word_off_s = {data_sram_addr[15:2], 2'b00};
    assign led_merge_s = merge_bytes({16'h0000, led_r}, data_sram_wdata, data_sram_wen);

    // Decode the word offset into one-hot register selects.
    always_comb begin
        sel_timer_s   = 1'b0;
        sel_compare_s = 1'b0;
        sel_led_s     = 1'b0;
        sel_num_s     = 1'b0;
        sel_switch_s  = 1'b0;
        sel_simu_s    = 1'b0;
        case (word_off_s)
            OFF_TIMER:   sel_timer_s   = 1'b1;
            OFF_COMPARE: sel_compare_s = 1'b1;
            OFF_LED:     sel_led_s     = 1'b1;
            OFF_NUM:     sel_num_s     = 1'b1;
            OFF_SWITCH:  sel_switch_s  = 1'b1;
            OFF_SIMU:    sel_simu_s    = 1'b1;
            default:     sel_timer_s   = 1'b0;
        endcase
    end

    // Read multiplexer over the pre-edge register values; unmapped offsets read 0.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        if (sel_timer_s) begin
            rd_mux_s = timer_r;
        end else if (sel_compare_s) begin
            rd_mux_s = compare_r;
        end else if (sel_led_s) begin
            rd_mux_s = {16'h0000, led_r};
        end else if (sel_num_s) begin
            rd_mux_s = num_r;
        end else if (sel_switch_s) begin
            rd_mux_s = {24'h00_0000, sw_sync_r};
        end else if (sel_simu_s) begin
            rd_mux_s = {31'h0000_0000, SIMU};
        end else begin
            rd_mux_s = 32'h0000_0000;
        end
    end

    // Free-running timer; a write replaces the increment for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= 32'h0000_0000;
        end else if (wr_s && sel_timer_s) begin
            timer_r <= merge_bytes(timer_r, data_sram_wdata, data_sram_wen);
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end

    // Writable configuration registers: COMPARE, LED and NUM.
    always_ff @(posedge clk) begin
        if (rst) begin
            compare_r <= 32'h0000_0000;
            led_r     <= 16'h0000;
            num_r     <= 32'h0000_0000;
        end else begin
            if (wr_s && sel_compare_s) begin
                compare_r <= merge_bytes(compare_r, data_sram_wdata, data_sram_wen);
            end else begin
                compare_r <= compare_r;
            end
            if (wr_s && sel_led_s) begin
                led_r <= led_merge_s[15:0];
            end else begin
                led_r <= led_r;
            end
            if (wr_s && sel_num_s) begin
                num_r <= merge_bytes(num_r, data_sram_wdata, data_sram_wen);
            end else begin
                num_r <= num_r;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_r <= 8'h00;
            sw_sync_r <= 8'h00;
        end else begin
            sw_meta_r <= switch;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Sticky compare-match interrupt; any COMPARE write clears it and wins over a match.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_int_r <= 1'b0;
        end else if (wr_s && sel_compare_s) begin
            timer_int_r <= 1'b0;
        end else if (timer_r == compare_r) begin
            timer_int_r <= 1'b1;
        end else begin
            timer_int_r <= timer_int_r;
        end
    end

    // Registered read data: zero for writes, misses and idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_s) begin
            rdata_r <= rd_mux_s;
        end else begin
            rdata_r <= 32'h0000_0000;
        end
    end

    assign data_sram_rdata = rdata_r;
    assign led             = led_r;
    assign num_data        = num_r;
    assign timer_int       = timer_int_r;

endmodule

// File: tb/tb_sram_confreg.sv
// Directed self-checking bench for sram_confreg (instantiated with SIMU = 1).
module tb_sram_confreg;

    localparam logic [31:0] BASE      = 32'h1faf_0000;
    localparam logic [31:0] A_TIMER   = 32'h1faf_e000;
    localparam logic [31:0] A_COMPARE = 32'h1faf_e004;
    localparam logic [31:0] A_LED     = 32'h1faf_f000;
    localparam logic [31:0] A_NUM     = 32'h1faf_f010;
    localparam logic [31:0] A_SWITCH  = 32'h1faf_f020;
    localparam logic [31:0] A_SIMU    = 32'h1faf_fff0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'b0000;
    logic [31:0] data_sram_addr = 32'h0000_0000;
    logic [31:0] data_sram_wdata = 32'h0000_0000;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch = 8'h00;
    logic [15:0] led;
    logic [31:0] num_data;
    logic        timer_int;

    int checks = 0;
    int errors = 0;

    sram_confreg #(.BASE(BASE), .SIMU(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .data_sram_en(data_sram_en),
        .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .switch(switch),
        .led(led),
        .num_data(num_data),
        .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        @(posedge clk);
        #1;
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = addr;
        @(posedge clk);
        #1;
        data = data_sram_rdata;
        data_sram_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        idle();
        idle();
        checks++; if (timer_int !== 1'b0) begin errors++; $display("FAIL reset_int: got %b expected 0", timer_int); end
        checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", data_sram_rdata); end
        checks++; if ({led, num_data} !== 48'h0) begin errors++; $display("FAIL reset_outs: got led=%h num=%h expected 0", led, num_data); end
        rst = 1'b0;
        do_read(A_TIMER, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_timer: got %h expected 0", d); end
        do_read(A_LED, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_led: got %h expected 0", d); end
        do_read(A_NUM, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_num: got %h expected 0", d); end
        do_read(A_COMPARE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_compare: got %h expected 0", d); end
        do_read(A_SIMU, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL simu_flag: got %h expected 1", d); end
    endtask

    task automatic test_byte_merge();
        logic [31:0] d;
        do_write(A_NUM, 4'b1111, 32'h1234_5678);
        checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata: got %h expected 0", data_sram_rdata); end
        do_write(A_NUM, 4'b1001, 32'hAA99_88BB);
        do_read(A_NUM, d);
        checks++; if (d !== 32'hAA34_56BB) begin errors++; $display("FAIL num_merge: got %h expected aa3456bb", d); end
        checks++; if (num_data !== 32'hAA34_56BB) begin errors++; $display("FAIL num_out: got %h expected aa3456bb", num_data); end
    endtask

    task automatic test_timer_wrap();
        logic [31:0] d;
        do_write(A_TIMER, 4'b1111, 32'hFFFF_FFFE);
        do_read(A_TIMER, d);
        checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL timer_rd0: got %h expected fffffffe", d); end
        do_read(A_TIMER, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_rd1: got %h expected ffffffff", d); end
        do_read(A_TIMER, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL timer_wrap: got %h expected 0", d); end
    endtask

    task automatic test_timer_int();
        // Timer wrapped onto COMPARE = 0, so the interrupt is already pending.
        checks++; if (timer_int !== 1'b1) begin errors++; $display("FAIL int_wrap_match: got %b expected 1", timer_int); end
        do_write(A_COMPARE, 4'b1111, 32'h0000_0020);
        checks++; if (timer_int !== 1'b0) begin errors++; $display("FAIL int_clear: got %b expected 0", timer_int); end
        do_write(A_TIMER, 4'b1111, 32'h0000_0010);
        for (int i = 0; i < 16; i++) idle();
        checks++; if (timer_int !== 1'b0) begin errors++; $display("FAIL int_early: got %b expected 0", timer_int); end
        idle();
        checks++; if (timer_int !== 1'b1) begin errors++; $display("FAIL int_rise: got %b expected 1", timer_int); end
        idle();
        checks++; if (timer_int !== 1'b1) begin errors++; $display("FAIL int_hold: got %b expected 1", timer_int); end
        do_write(A_COMPARE, 4'b1111, 32'h0000_0100);
        checks++; if (timer_int !== 1'b0) begin errors++; $display("FAIL int_cmp_write: got %b expected 0", timer_int); end
        do_write(A_COMPARE, 4'b1111, 32'h0000_0060);
        do_write(A_TIMER, 4'b1111, 32'h0000_005E);
        idle();
        idle();
        // TIMER now equals COMPARE; a COMPARE write in this cycle suppresses the set.
        do_write(A_COMPARE, 4'b0001, 32'h0000_0060);
        checks++; if (timer_int !== 1'b0) begin errors++; $display("FAIL int_write_wins: got %b expected 0", timer_int); end
        idle();
        checks++; if (timer_int !== 1'b0) begin errors++; $display("FAIL int_no_pulse: got %b expected 0", timer_int); end
    endtask

    task automatic test_switch();
        logic [31:0] d;
        switch = 8'hA5;
        do_read(A_SWITCH, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL switch_lat1: got %h expected 0", d); end
        do_read(A_SWITCH, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL switch_lat2: got %h expected 0", d); end
        do_read(A_SWITCH, d);
        checks++; if (d !== 32'hA5) begin errors++; $display("FAIL switch_val: got %h expected a5", d); end
        do_write(A_SWITCH, 4'b1111, 32'h0000_0000);
        do_read(A_SWITCH, d);
        checks++; if (d !== 32'hA5) begin errors++; $display("FAIL switch_ro: got %h expected a5", d); end
    endtask

    task automatic test_led();
        logic [31:0] d;
        do_write(A_LED, 4'b1111, 32'hFFFF_FFFF);
        checks++; if (led !== 16'hFFFF) begin errors++; $display("FAIL led_out: got %h expected ffff", led); end
        do_read(A_LED, d);
        checks++; if (d !== 32'h0000_FFFF) begin errors++; $display("FAIL led_read: got %h expected 0000ffff", d); end
    endtask

    task automatic test_no_hit();
        logic [31:0] d;
        do_write(32'h1fae_f000, 4'b1111, 32'h0000_0000);
        checks++; if (led !== 16'hFFFF) begin errors++; $display("FAIL miss_led: got %h expected ffff", led); end
        do_write(32'h1fbf_f010, 4'b1111, 32'h0000_0000);
        checks++; if (num_data !== 32'hAA34_56BB) begin errors++; $display("FAIL miss_num: got %h expected aa3456bb", num_data); end
        do_read(32'h1fae_f010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL miss_read: got %h expected 0", d); end
        do_write(32'h1faf_f004, 4'b1111, 32'h1111_1111);
        do_read(32'h1faf_f004, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped: got %h expected 0", d); end
        do_read(32'h1faf_f013, d);
        checks++; if (d !== 32'hAA34_56BB) begin errors++; $display("FAIL addr_low_bits: got %h expected aa3456bb", d); end
        idle();
        checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL idle_rdata: got %h expected 0", data_sram_rdata); end
    endtask

    task automatic test_reset_write();
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b1111;
        data_sram_addr  = A_LED;
        data_sram_wdata = 32'h0000_1234;
        rst = 1'b1;
        idle();
        rst = 1'b0;
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL rst_led_write: got %h expected 0", led); end
        checks++; if (num_data !== 32'h0) begin errors++; $display("FAIL rst_num: got %h expected 0", num_data); end
    endtask

    initial begin
        test_reset();
        test_byte_merge();
        test_timer_wrap();
        test_timer_int();
        test_switch();
        test_led();
        test_no_hit();
        test_reset_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
